// File: rtl/hazard_pkg.sv
// Shared hazard-unit types and default geometry for the issue-stage scoreboard,
// the pipeline top and the ALU latency table.
package hazard_pkg;

    localparam int unsigned NREG  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned LAT_W = 3;

    // Latency code meaning "completes later via wb_valid_i".
    localparam int unsigned LAT_UNKNOWN = 0;

    typedef struct packed {
        logic [LAT_W-1:0] cnt;
        logic             unk;
    } sb_entry_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: a saturating latency countdown plus an unknown-latency
// flag that is cleared by a writeback completion.
module sb_entry
    import hazard_pkg::*;
#(
    parameter int unsigned LAT_W = hazard_pkg::LAT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_cnt_i,
    input  logic             load_unk_i,
    input  logic             wb_clr_i,
    output logic             busy_o,
    output logic             unk_only_o
);

    typedef struct packed {
        logic [LAT_W-1:0] cnt;
        logic             unk;
    } entry_t;

    entry_t state_q;
    entry_t state_d;

    // A new record replaces whatever was pending, including any decrement or clear.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d.cnt = load_cnt_i;
            state_d.unk = load_unk_i;
        end else begin
            if (state_q.cnt != '0) begin
                state_d.cnt = state_q.cnt - LAT_W'(1);
            end
            if (wb_clr_i) begin
                state_d.unk = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy_o     = (state_q.cnt != '0) | state_q.unk;
    assign unk_only_o = (state_q.cnt == '0) & state_q.unk;

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register issue hazard scoreboard: tracks in-flight writes with fixed or
// unknown latency and stalls issue on RAW/WAW against pending registers.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NREG  = hazard_pkg::NREG,
    parameter int unsigned AW    = hazard_pkg::AW,
    parameter int unsigned LAT_W = hazard_pkg::LAT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             issue_valid_i,
    input  logic [AW-1:0]    issue_rs1_i,
    input  logic [AW-1:0]    issue_rs2_i,
    input  logic [1:0]       issue_rs_used_i,
    input  logic             issue_we_i,
    input  logic [AW-1:0]    issue_rd_i,
    input  logic [LAT_W-1:0] issue_lat_i,
    input  logic             flush_i,
    input  logic             wb_valid_i,
    input  logic [AW-1:0]    wb_rd_i,
    output logic             stall_o,
    output logic [NREG-1:0]  busy_o
);

    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  unk_only;
    logic [NREG-1:0]  wb_hit;
    logic [NREG-1:0]  eff_busy;
    logic             raw;
    logic             waw;
    logic             rd_nz;
    logic             accept_we;
    logic             lat_unknown;
    logic [LAT_W-1:0] load_cnt;

    assign busy[0]     = 1'b0;
    assign unk_only[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        sb_entry #(
            .LAT_W (LAT_W)
        ) u_entry (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .load_i     (accept_we & (issue_rd_i == AW'(r))),
            .load_cnt_i (load_cnt),
            .load_unk_i (lat_unknown),
            .wb_clr_i   (wb_valid_i & (wb_rd_i == AW'(r))),
            .busy_o     (busy[r]),
            .unk_only_o (unk_only[r])
        );
    end

    // An unknown-latency entry completing this cycle is treated as already free.
    always_comb begin
        wb_hit = '0;
        if (wb_valid_i) begin
            wb_hit[wb_rd_i] = 1'b1;
        end
        eff_busy = busy & ~(unk_only & wb_hit);
    end

    assign rd_nz = (issue_rd_i != '0);
    assign raw   = (issue_rs_used_i[0] & eff_busy[issue_rs1_i])
                 | (issue_rs_used_i[1] & eff_busy[issue_rs2_i]);
    assign waw   = issue_we_i & rd_nz & eff_busy[issue_rd_i];

    assign stall_o = issue_valid_i & ~flush_i & (raw | waw);

    assign accept_we   = issue_valid_i & ~flush_i & ~stall_o & issue_we_i & rd_nz;
    assign lat_unknown = (issue_lat_i == LAT_W'(LAT_UNKNOWN));
    assign load_cnt    = lat_unknown ? '0 : issue_lat_i - LAT_W'(1);

    assign busy_o = busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed hazard scenarios plus random
// traffic, checked against a ready-time model of the register file.
module tb_hazard_scoreboard;

    localparam int N = 32;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            issue_valid_i;
    logic [4:0]      issue_rs1_i;
    logic [4:0]      issue_rs2_i;
    logic [1:0]      issue_rs_used_i;
    logic            issue_we_i;
    logic [4:0]      issue_rd_i;
    logic [2:0]      issue_lat_i;
    logic            flush_i;
    logic            wb_valid_i;
    logic [4:0]      wb_rd_i;
    logic            stall_o;
    logic [N-1:0]    busy_o;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NREG  (32),
        .AW    (5),
        .LAT_W (3)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .issue_valid_i   (issue_valid_i),
        .issue_rs1_i     (issue_rs1_i),
        .issue_rs2_i     (issue_rs2_i),
        .issue_rs_used_i (issue_rs_used_i),
        .issue_we_i      (issue_we_i),
        .issue_rd_i      (issue_rd_i),
        .issue_lat_i     (issue_lat_i),
        .flush_i         (flush_i),
        .wb_valid_i      (wb_valid_i),
        .wb_rd_i         (wb_rd_i),
        .stall_o         (stall_o),
        .busy_o          (busy_o)
    );

    typedef struct {
        bit           stall;
        logic [N-1:0] busy;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: a register is pending until the cycle its result becomes forwardable,
    // or indefinitely while an unknown-latency result is outstanding.
    int   ready_at[N];
    bit   unk_m[N];
    int   cyc = 0;

    function automatic void model_clear();
        for (int r = 0; r < N; r++) begin
            ready_at[r] = 0;
            unk_m[r]    = 1'b0;
        end
    endfunction

    function automatic bit m_busy(int r);
        return (r != 0) && ((ready_at[r] > cyc) || unk_m[r]);
    endfunction

    function automatic bit m_eff(int r, bit wbv, int wbrd);
        return m_busy(r) && !(wbv && (wbrd == r) && unk_m[r]);
    endfunction

    task automatic cycle(input bit v, input int rs1, input int rs2, input bit [1:0] used,
                         input bit we, input int rd, input int lat, input bit fl,
                         input bit wbv, input int wbrd);
        exp_t e;
        bit   hz;
        @(negedge clk);
        issue_valid_i   = v;
        issue_rs1_i     = 5'(rs1);
        issue_rs2_i     = 5'(rs2);
        issue_rs_used_i = used;
        issue_we_i      = we;
        issue_rd_i      = 5'(rd);
        issue_lat_i     = 3'(lat);
        flush_i         = fl;
        wb_valid_i      = wbv;
        wb_rd_i         = 5'(wbrd);
        e.busy = '0;
        for (int r = 0; r < N; r++) e.busy[r] = m_busy(r);
        hz = (used[0] && m_eff(rs1, wbv, wbrd)) || (used[1] && m_eff(rs2, wbv, wbrd))
           || (we && rd != 0 && m_eff(rd, wbv, wbrd));
        e.stall = rst_i && v && !fl && hz;
        e.cyc   = cyc;
        q.push_back(e);
        if (!rst_i) begin
            model_clear();
        end else begin
            if (wbv && wbrd != 0) unk_m[wbrd] = 1'b0;
            if (v && !fl && !e.stall && we && rd != 0) begin
                if (lat != 0) begin
                    ready_at[rd] = cyc + lat;
                    unk_m[rd]    = 1'b0;
                end else begin
                    ready_at[rd] = 0;
                    unk_m[rd]    = 1'b1;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_idle_inputs();
        issue_valid_i   = 1'b0;
        issue_rs1_i     = '0;
        issue_rs2_i     = '0;
        issue_rs_used_i = '0;
        issue_we_i      = 1'b0;
        issue_rd_i      = '0;
        issue_lat_i     = '0;
        flush_i         = 1'b0;
        wb_valid_i      = 1'b0;
        wb_rd_i         = '0;
    endtask

    // Monitor: outputs are valid every cycle; compare well after the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (stall_o !== e.stall) begin
                    errors++;
                    $display("FAIL stall cyc=%0d got=%b exp=%b", e.cyc, stall_o, e.stall);
                end
                checks++;
                if (busy_o !== e.busy) begin
                    errors++;
                    $display("FAIL busy cyc=%0d got=%h exp=%h", e.cyc, busy_o, e.busy);
                end
            end
        end
    end

    initial begin
        model_clear();
        set_idle_inputs();
        rst_i = 1'b0;
        // Stall must stay low while held in reset, even with a presented instruction.
        cycle(1, 1, 2, 2'b11, 1, 3, 2, 0, 0, 0);
        cycle(1, 3, 3, 2'b11, 1, 3, 0, 0, 0, 0);
        @(negedge clk);
        set_idle_inputs();
        rst_i = 1'b1;

        // Fixed latency 2 producer followed by a dependent reader.
        cycle(1, 0, 0, 2'b00, 1, 5, 2, 0, 0, 0);
        cycle(1, 5, 1, 2'b11, 1, 6, 1, 0, 0, 0);
        cycle(1, 5, 1, 2'b11, 1, 6, 1, 0, 0, 0);
        idle();

        // Unknown latency: reader held for 10 cycles, released by the writeback.
        cycle(1, 0, 0, 2'b00, 1, 7, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 7, 0, 2'b01, 0, 0, 1, 0, 0, 0);
        cycle(1, 7, 0, 2'b01, 0, 0, 1, 0, 1, 7);
        idle();

        // Writes to x0 never record anything.
        cycle(1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 2'b11, 1, 0, 3, 0, 0, 0);
        idle();

        // WAW against a latency-7 write of x3.
        cycle(1, 0, 0, 2'b00, 1, 3, 7, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(1, 0, 0, 2'b00, 1, 3, 2, 0, 0, 0);

        // Flushed issue records nothing; writeback to a counted entry changes nothing.
        cycle(1, 0, 0, 2'b00, 1, 9, 4, 1, 0, 0);
        cycle(1, 0, 0, 2'b00, 1, 12, 5, 0, 1, 3);
        cycle(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 12);
        idle();

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom % 4) != 0, $urandom % 8, $urandom % 8, 2'($urandom),
                  $urandom % 2, $urandom % 8, $urandom % 8, ($urandom % 10) == 0,
                  ($urandom % 3) == 0, $urandom % 8);
        end

        // Asynchronous reset mid-run with long-lived entries pending.
        cycle(1, 0, 0, 2'b00, 1, 10, 7, 0, 0, 0);
        cycle(1, 0, 0, 2'b00, 1, 11, 0, 0, 0, 0);
        @(negedge clk);
        #3;
        rst_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== '0) begin
            errors++;
            $display("FAIL async_reset_busy got=%h exp=0", busy_o);
        end
        model_clear();
        cycle(1, 10, 11, 2'b11, 1, 10, 3, 0, 0, 0);
        @(negedge clk);
        set_idle_inputs();
        rst_i = 1'b1;
        cycle(1, 10, 11, 2'b11, 1, 11, 3, 0, 0, 0);
        cycle(1, 11, 10, 2'b11, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom % 4) != 0, $urandom % 8, $urandom % 8, 2'($urandom),
                  $urandom % 2, $urandom % 8, $urandom % 8, ($urandom % 10) == 0,
                  ($urandom % 3) == 0, $urandom % 8);
        end
        idle();

        @(negedge clk);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised issue-stage hazard unit for the pipelined RISC-V core; it generalises the single stall output into a per-register scoreboard. It records every in-flight register write with its result latency, fixed or unknown, and holds issue while a source or destination operand is still pending. An unknown latency covers data-memory misses and multi-cycle units. It sits between decode and the ID/EX register and drives the PC/IF-ID write enables through `stall_o`.

## Interface
- `NREG`, 32: architectural registers; register 0 is hard-wired zero.
- `AW`, 5: register address width, equal to log2(NREG).
- `LAT_W`, 3: latency field width; fixed latencies range 1..2^LAT_W-1.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `issue_valid_i` in 1: decode presents an instruction this cycle.
- `issue_rs1_i`, `issue_rs2_i` in AW: source register addresses.
- `issue_rs_used_i` in 2: bit0 means rs1 is read, bit1 means rs2 is read.
- `issue_we_i` in 1: the instruction writes `issue_rd_i`.
- `issue_rd_i` in AW: destination register.
- `issue_lat_i` in LAT_W: cycles until the result is forwardable. 0 means unknown latency; completion is signalled later by `wb_valid_i`.
- `flush_i` in 1: squash the instruction presented this cycle.
- `wb_valid_i` in 1: completion of an unknown-latency result.
- `wb_rd_i` in AW: register completed by `wb_valid_i`.
- `stall_o` out 1: hold the issue stage; combinational.
- `busy_o` out NREG: per-register pending vector, registered (debug and verification).

## Operation
- Each register has one entry: a `cnt` field (LAT_W bits) and an `unk` bit. The entry is busy when `cnt != 0` or `unk` is set. Entry 0 is never busy.
- **Acceptance:** an instruction is accepted when `issue_valid_i & ~flush_i & ~stall_o`.
- **Recording a write:** when an accepted instruction has `issue_we_i` set and `rd != 0`:
  - lat = L with L ≥ 1: load `cnt = L-1` and clear `unk`. L = 1 therefore records nothing.
  - lat = 0: set `unk` and clear `cnt`.
- **Decrement:** every cycle, each entry with `cnt != 0` decrements by 1, saturating at 0. The load on acceptance overrides the decrement for that entry.
- **Completion:** `wb_valid_i` clears `unk` of `wb_rd_i`. When it targets an entry with `unk = 0`, it has no effect. When it targets register 0, it has no effect.
- **Stall:** `stall_o = issue_valid_i & ~flush_i & (RAW | WAW)`.
  - RAW: a used source is busy.
  - WAW: `issue_we_i` is set and rd ≠ 0 and rd is busy.
- **Completion bypass:** a register whose only pending reason is `unk`, and which matches `wb_rd_i` while `wb_valid_i` is set, counts as free in the same cycle.
- **Simultaneous events:**
  - Issue and `wb_valid_i` targeting the same rd: cannot both take effect, because WAW stalls the issue unless the bypass frees it. When the bypass frees it, the issue's new value wins.
  - Flush and issue in the same cycle: the issue is ignored and existing entries are untouched.
- **Reset:** all entries are cleared asynchronously. `busy_o` = 0 and `stall_o` = 0 while in reset.

## Timing
- Producer accepted in cycle t with latency L ≥ 1: a dependent instruction is accepted no earlier than cycle t+L. It stalls in cycles t+1..t+L-1.
- Unknown latency: a dependent instruction stalls until the cycle in which `wb_valid_i` names its register, and is accepted in that cycle via the bypass.
- `stall_o` has zero-cycle latency from the inputs. `busy_o` reflects state after the last edge.
- Reset deasserting mid-operation leaves all in-flight state discarded; no entry survives.
- Counter wrap is impossible, because counters saturate at 0 and load at most 2^LAT_W-2.

## Structure
- `hazard_pkg` holds:
  - the `LAT_UNKNOWN` (= 0) constant;
  - the `sb_entry_t` struct {cnt, unk};
  - the default `NREG`/`AW`/`LAT_W` localparams, shared with the pipeline top and the ALU latency table.
- One sub-module, `sb_entry`, holds one register's counter, its unknown bit, its load/decrement/clear logic and its busy output. It is instantiated NREG-1 times in a generate loop; entry 0 is tied off.

## Test plan
- Reset with `rst_i` = 0 mid-run with several entries busy -> `busy_o` = 0 immediately; `stall_o` = 0 after release.
- Issue `lw x5` lat 2 at t; `add x6,x5,x1` at t+1 -> `stall_o` = 1 at t+1; add accepted at t+2; `busy_o[5]` = 1 only during t+1.
- Issue rd = x7 lat 0; dependent on x7 held for 10 cycles -> stall for all 10; `wb_valid_i` with rd = x7 in cycle 11 -> `stall_o` = 0 in cycle 11; `busy_o[7]` = 0 in cycle 12.
- Issue rd = x0 lat 0, then a reader of x0 -> never stalls; `busy_o` = 0.
- Issue x3 lat 7, then another writer of x3 at t+1 -> WAW stall for cycles t+1..t+6; accepted at t+7.
- `flush_i` = 1 with an issue of rd = x9 lat 4 -> `stall_o` = 0 and `busy_o[9]` stays 0. `wb_valid_i` for a non-unknown entry -> no state change.
